// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU behind the 5-bit opcode set.
//
// Single-cycle ops register their result and flags on the edge that samples
// start, so done pulses in the following cycle. MOD with a non-zero divisor
// runs a restoring divider for W cycles; busy is high while it iterates.
//
// Ports:
//   CLK      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only while busy is low
//   op       5-bit opcode
//   a, b     operands (dividend/divisor for MOD, b[SW-1:0] is the shift amount)
//   busy     high while MOD iterates
//   done     one-cycle completion pulse; result/flags valid from this cycle
//   result   registered result, held until the next done
//   zero     result == 0, registered with result
//   ovf      signed overflow (ADD/SUB) or carry/borrow (ADDU/SUBU)
//   dbz      MOD with b == 0
//   illegal  opcode outside the supported set
module alu_seq #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(W)
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic         start,
  input  logic [4:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         ovf,
  output logic         dbz,
  output logic         illegal
);

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_SLL  = 5'b00010,
    OP_SRL  = 5'b00011,
    OP_SUBU = 5'b01000,
    OP_ADDU = 5'b01001,
    OP_AND  = 5'b01010,
    OP_SLRA = 5'b01011,
    OP_SEQ  = 5'b01100,
    OP_MOD  = 5'b01111
  } op_t;

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  state_t        state_q;
  logic          armed_q;     // low for the first edge after reset release
  logic [W-1:0]  div_a_q;     // dividend, shifted out MSB-first
  logic [W-1:0]  div_b_q;     // latched divisor
  logic [W-1:0]  div_rem_q;   // partial remainder
  logic [CW-1:0] cnt_q;

  op_t           op_e;
  logic [SW-1:0] shamt;
  logic [W:0]    sum;
  logic [W:0]    dif;
  logic [W-1:0]  res_d;
  logic          ovf_d;
  logic          ill_d;
  logic          is_mod;
  logic          div_start;

  logic [W:0]    rem_sh;
  logic [W:0]    rem_try;
  logic [W-1:0]  rem_d;

  assign op_e      = op_t'(op);
  assign shamt     = b[SW-1:0];
  assign is_mod    = (op_e == OP_MOD);
  assign div_start = is_mod && (b != '0);

  // Single-cycle datapath. For MOD this only matters on the divide-by-zero
  // path, where the dividend is returned unchanged.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    res_d = '0;
    ovf_d = 1'b0;
    ill_d = 1'b0;
    case (op_e)
      OP_ADD: begin
        res_d = sum[W-1:0];
        ovf_d = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res_d = dif[W-1:0];
        ovf_d = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
      end
      OP_SLL:  res_d = a << shamt;
      OP_SRL:  res_d = a >> shamt;
      OP_SUBU: begin
        res_d = dif[W-1:0];
        ovf_d = dif[W];
      end
      OP_ADDU: begin
        res_d = sum[W-1:0];
        ovf_d = sum[W];
      end
      OP_AND:  res_d = a & b;
      OP_SLRA: res_d = $signed(a) >>> shamt;
      OP_SEQ:  res_d = {{(W-1){1'b0}}, (a == b)};
      OP_MOD:  res_d = a;
      default: ill_d = 1'b1;
    endcase
  end

  // One restoring step. The remainder is always below the divisor, so after
  // the shift it fits in W+1 bits and the difference's top bit is its sign.
  always_comb begin
    rem_sh  = {div_rem_q, div_a_q[W-1]};
    rem_try = rem_sh - {1'b0, div_b_q};
    rem_d   = rem_try[W] ? rem_sh[W-1:0] : rem_try[W-1:0];
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      div_rem_q <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      done    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && armed_q) begin
            if (div_start) begin
              div_a_q   <= a;
              div_b_q   <= b;
              div_rem_q <= '0;
              cnt_q     <= '0;
              busy      <= 1'b1;
              state_q   <= S_DIV;
            end else begin
              done    <= 1'b1;
              result  <= res_d;
              zero    <= (res_d == '0);
              ovf     <= ovf_d;
              dbz     <= is_mod;
              illegal <= ill_d;
            end
          end
        end
        S_DIV: begin
          div_rem_q <= rem_d;
          div_a_q   <= div_a_q << 1;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= rem_d;
            zero    <= (rem_d == '0);
            ovf     <= 1'b0;
            dbz     <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int unsigned W    = 8;
  localparam int          MASK = (1 << W) - 1;
  localparam int          SMAX = (1 << (W - 1)) - 1;
  localparam int          SMIN = -(1 << (W - 1));
  localparam int          SHM  = (1 << $clog2(W)) - 1;

  logic         CLK;
  logic         reset_n;
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         dbz;
  logic         illegal;

  int tests  = 0;
  int failed = 0;

  alu_seq #(.W(W)) dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf),
    .dbz(dbz), .illegal(illegal)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    bit         ovf;
    bit         dbz;
    bit         ill;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode's meaning.
  function automatic void ref_alu(input logic [4:0] o, input int ua, input int ub,
                                  output int r, output bit rovf, output bit rdbz,
                                  output bit rill);
    int sa, sb, s, sh;
    sa = (ua > SMAX) ? ua - (1 << W) : ua;
    sb = (ub > SMAX) ? ub - (1 << W) : ub;
    sh = ub & SHM;
    r = 0; rovf = 0; rdbz = 0; rill = 0;
    case (o)
      5'b00000: begin s = sa + sb; r = s & MASK; rovf = (s > SMAX) || (s < SMIN); end
      5'b00001: begin s = sa - sb; r = s & MASK; rovf = (s > SMAX) || (s < SMIN); end
      5'b00010: r = (ua << sh) & MASK;
      5'b00011: r = ua >> sh;
      5'b01000: begin r = (ua - ub) & MASK; rovf = ua < ub; end
      5'b01001: begin r = (ua + ub) & MASK; rovf = (ua + ub) > MASK; end
      5'b01010: r = ua & ub;
      5'b01011: r = (sa >>> sh) & MASK;
      5'b01100: r = (ua == ub) ? 1 : 0;
      5'b01111: begin
        if (ub == 0) begin r = ua; rdbz = 1; end
        else r = ua % ub;
      end
      default: rill = 1;
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [4:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] er, input bit eovf,
                        input bit edbz, input bit eill);
    int cyc, nbusy, exp_lat;
    bit long_div;
    long_div = (o == 5'b01111) && (bv != '0);
    exp_lat  = long_div ? W + 1 : 1;
    @(negedge CLK);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 1; nbusy = 0;
    while (!done && cyc < 4 * W) begin
      if (busy) nbusy++;
      @(posedge CLK); #1;
      cyc++;
    end
    chk({nm, ".latency"}, cyc, exp_lat);
    chk({nm, ".busycyc"}, nbusy, long_div ? W : 0);
    chk({nm, ".busy_at_done"}, busy, 0);
    chk({nm, ".result"}, result, er);
    chk({nm, ".zero"}, zero, (er == '0));
    chk({nm, ".ovf"}, ovf, eovf);
    chk({nm, ".dbz"}, dbz, edbz);
    chk({nm, ".illegal"}, illegal, eill);
    @(posedge CLK); #1;
    chk({nm, ".single_pulse"}, done, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int cyc, ndone, r;
    bit rovf, rdbz, rill;
    logic [4:0] ro;
    logic [7:0] ra, rb;
    logic [4:0] legal[10];

    legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01000,
              5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01111};

    vecs.push_back('{"add_ovf",   5'b00000, 8'd100, 8'd50,  8'h96, 1, 0, 0});
    vecs.push_back('{"addu_cy",   5'b01001, 8'd200, 8'd100, 8'h2C, 1, 0, 0});
    vecs.push_back('{"add_m1p1",  5'b00000, 8'hFF,  8'h01,  8'h00, 0, 0, 0});
    vecs.push_back('{"addu_wrap", 5'b01001, 8'hFF,  8'h01,  8'h00, 1, 0, 0});
    vecs.push_back('{"sub_ovf",   5'b00001, 8'h80,  8'h01,  8'h7F, 1, 0, 0});
    vecs.push_back('{"sub_neg",   5'b00001, 8'd5,   8'd7,   8'hFE, 0, 0, 0});
    vecs.push_back('{"subu_brw",  5'b01000, 8'd5,   8'd7,   8'hFE, 1, 0, 0});
    vecs.push_back('{"subu_ok",   5'b01000, 8'd7,   8'd5,   8'h02, 0, 0, 0});
    vecs.push_back('{"slra",      5'b01011, 8'h80,  8'd3,   8'hF0, 0, 0, 0});
    vecs.push_back('{"slra_pos",  5'b01011, 8'h7F,  8'd7,   8'h00, 0, 0, 0});
    vecs.push_back('{"srl",       5'b00011, 8'h80,  8'd3,   8'h10, 0, 0, 0});
    vecs.push_back('{"sll_amt1",  5'b00010, 8'h81,  8'd9,   8'h02, 0, 0, 0});
    vecs.push_back('{"seq_eq",    5'b01100, 8'h3C,  8'h3C,  8'h01, 0, 0, 0});
    vecs.push_back('{"seq_ne",    5'b01100, 8'h3C,  8'h3D,  8'h00, 0, 0, 0});
    vecs.push_back('{"and",       5'b01010, 8'hF0,  8'h3C,  8'h30, 0, 0, 0});
    vecs.push_back('{"mod_dbz",   5'b01111, 8'd55,  8'd0,   8'd55, 0, 1, 0});
    vecs.push_back('{"add_1p1",   5'b00000, 8'd1,   8'd1,   8'd2,  0, 0, 0});
    vecs.push_back('{"ill_10100", 5'b10100, 8'h12,  8'h34,  8'h00, 0, 0, 1});
    vecs.push_back('{"ill_00100", 5'b00100, 8'hFF,  8'hFF,  8'h00, 0, 0, 1});
    vecs.push_back('{"mod_200_7", 5'b01111, 8'd200, 8'd7,   8'd4,  0, 0, 0});
    vecs.push_back('{"mod_5_9",   5'b01111, 8'd5,   8'd9,   8'd5,  0, 0, 0});
    vecs.push_back('{"mod_255_1", 5'b01111, 8'd255, 8'd1,   8'd0,  0, 0, 0});
    vecs.push_back('{"mod_ff_ff", 5'b01111, 8'd255, 8'd255, 8'd0,  0, 0, 0});
    vecs.push_back('{"mod_fe_ff", 5'b01111, 8'd254, 8'd255, 8'd254, 0, 0, 0});

    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #3;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.result", result, 0);
    chk("rst.zero", zero, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.dbz", dbz, 0);
    chk("rst.illegal", illegal, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); reset_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].ovf, vecs[i].dbz, vecs[i].ill);

    // Back-to-back single-cycle ops: second start issued in the done cycle.
    @(negedge CLK);
    start = 1'b1; op = 5'b00000; a = 8'd3; b = 8'd4;
    @(posedge CLK); #1;
    chk("b2b.done1", done, 1);
    chk("b2b.res1", result, 8'd7);
    op = 5'b01010; a = 8'hF0; b = 8'h3C;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("b2b.done2", done, 1);
    chk("b2b.res2", result, 8'h30);
    @(posedge CLK); #1;
    chk("b2b.idle", done, 0);

    // Remainder of 200 by 7 with a stray ADD start while busy.
    @(negedge CLK);
    start = 1'b1; op = 5'b01111; a = 8'd200; b = 8'd7;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 4 * W) begin
      if (cyc == 2) begin start = 1'b1; op = 5'b00000; a = 8'd1; b = 8'd1; end
      else start = 1'b0;
      @(posedge CLK); #1;
      cyc++;
    end
    start = 1'b0;
    chk("modign.latency", cyc, W + 1);
    chk("modign.result", result, 8'd4);
    chk("modign.dbz", dbz, 0);
    ndone = 0;
    repeat (4) begin @(posedge CLK); #1; if (done) ndone++; end
    chk("modign.no_queued", ndone, 0);

    // Reset in the middle of a division.
    @(negedge CLK);
    start = 1'b1; op = 5'b01111; a = 8'd255; b = 8'd2;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("abort.busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.result", result, 0);
    chk("abort.done", done, 0);
    chk("abort.zero", zero, 0);
    @(posedge CLK); #1;
    start = 1'b1; op = 5'b00000; a = 8'd9; b = 8'd9;
    @(negedge CLK); reset_n = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    ndone = (done) ? 1 : 0;
    repeat (W + 3) begin @(posedge CLK); #1; if (done) ndone++; end
    chk("abort.no_done", ndone, 0);
    chk("abort.result_held", result, 0);
    run_op("abort.add_after", 5'b00000, 8'd1, 8'd1, 8'd2, 0, 0, 0);

    // Randomized against the reference model.
    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(0, 11);
      ro  = (sel < 10) ? legal[sel] : 5'($urandom_range(0, 31));
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      ref_alu(ro, int'(ra), int'(rb), r, rovf, rdbz, rill);
      run_op($sformatf("rnd%0d_op%b", n, ro), ro, ra, rb, 8'(r), rovf, rdbz, rill);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
